ila_trigger_gen: RTL and testbench
==================================

// Module: ila_trigger_gen
// PURPOSE
//  Upstream trigger qualifier for the internal logic analyzer capture stage.
//  - Watches the probed data bus against a masked pattern (level, edge or change) with an optional consecutive-hit count.
//  - Emits a latched i_trigger for the stop/holdoff logic once the capture buffer reports primed.
//  - Sits between the probed FPGA signals and the capture top's i_trigger input.
// PARAMETERS
//  DATA_WIDTH   `DATA_WIDTH (8)  width of probed bus, pattern and mask
//  COUNT_WIDTH  8                width of consecutive-hit counter / i_match_count
// PORTS
//  clk            in   1            single system clock, all logic on rising edge
//  reset          in   1            synchronous, active-high reset
//  i_data         in   DATA_WIDTH   probed signals (same bus fed to capture top)
//  i_pattern      in   DATA_WIDTH   compare value, latched on arm
//  i_mask         in   DATA_WIDTH   1 = bit participates in compare, latched on arm
//  i_mode         in   2            00 LEVEL, 01 RISING, 10 FALLING, 11 CHANGE; latched on arm
//  i_match_count  in   COUNT_WIDTH  LEVEL mode: consecutive hits required (0 treated as 1)
//  i_arm          in   1            1-cycle pulse: start a trigger search
//  i_disarm       in   1            1-cycle pulse: abort/clear, return to IDLE
//  i_force        in   1            1-cycle pulse: fire immediately when armed
//  i_primed       in   1            capture buffer primed flag from the write stage
//  o_trigger      out  1            trigger to capture top; held high once fired
//  o_armed        out  1            1 while searching (ARMED state)
//  o_state        out  2            IDLE=0, WAIT_PRIMED=1, ARMED=2, FIRED=3
// BEHAVIOUR
//  Reset: state IDLE, o_trigger=0, o_armed=0, o_state=0; sample regs, hit counter and prev_valid all 0.
//  Pipeline
//   - i_data registered into d_q; previous sample held in d_p.
//   - hit is computed from d_q/d_p; o_trigger is registered.
//   - Latency: a qualifying i_data at edge N raises o_trigger at edge N+2.
//  Hit rules (m = latched mask)
//   - LEVEL:   (d_q & m) == (pat & m)
//   - RISING:  prev_valid & !eq(d_p) & eq(d_q)
//   - FALLING: prev_valid & eq(d_p) & !eq(d_q)
//   - CHANGE:  prev_valid & ((d_q ^ d_p) & m) != 0
//   - mask=0: LEVEL hits every cycle; CHANGE never hits.
//   - prev_valid clears on entry to ARMED and sets after the first sample taken in ARMED.
//   - Edge/change modes therefore never fire on the first ARMED sample.
//  Counter (LEVEL only)
//   - Increments on hit and clears on miss; saturates at all-ones.
//   - Fires when count+1 >= max(i_match_count,1).
//   - i_match_count is ignored in edge/change modes: the first hit fires.
//  FSM
//   - IDLE -> WAIT_PRIMED on i_arm; pattern, mask, mode and count are latched that cycle.
//   - WAIT_PRIMED -> ARMED when i_primed=1; hits are ignored while waiting.
//   - ARMED -> FIRED on qualified hit or i_force.
//   - WAIT_PRIMED -> FIRED on i_force.
//   - FIRED holds o_trigger=1 until i_disarm or reset.
//   - i_disarm in any state -> IDLE next cycle, o_trigger=0, counter cleared.
//   - i_disarm beats i_arm/i_force in the same cycle.
//   - i_arm outside IDLE is ignored; config inputs change-ignored outside IDLE.
//   - i_primed dropping in ARMED -> back to WAIT_PRIMED, counter cleared.
//   - reset mid-operation: full return to reset values next edge, no trigger glitch.
// STRUCTURE
//  - Mode encodings and the o_state encodings are added to define.v as `TRIG_* constants, shared with the stop block and bench.
//  - One sub-module, ila_trigger_match: registered sample and previous sample, masked compare, and edge/change detect producing hit.
//  - The FSM and counter stay in the top.
// TESTING (DATA_WIDTH=8, i_primed=1 unless noted)
//  1 LEVEL pat=A5 mask=FF cnt=3; data A5,A5,00,A5,A5,A5 -> o_trigger rises 2 edges after the 6th sample only.
//  2 RISING mask=01 pat=01; data 01 at arm, 01, 00, 01 -> no fire on the first sample; fire 2 edges after the final 01.
//  3 i_primed=0, arm LEVEL mask=00 -> o_state=1, o_trigger=0 for 10 cycles; raise i_primed -> o_state=2, then o_trigger=1 two edges later.
//  4 In FIRED, pulse i_arm+i_disarm together -> o_state=0, o_trigger=0 next edge; a new i_arm is then accepted.
//  5 ARMED CHANGE mask=F0, data toggles only low nibble -> no trigger; i_force -> o_trigger=1 next edge.
//  6 reset asserted in ARMED mid count (2 of 3 hits) -> all outputs 0 next edge; after re-arm, 3 fresh hits are needed.

Source files
------------

// File: rtl/ila_trigger_gen_pkg.sv
// ----------------------------------------------------------------------------
// ila_trigger_gen_pkg
// Shared constants and encodings for the ILA trigger qualifier. The mode and
// state encodings are also used by the stop/holdoff block and the bench, so
// they live here rather than inside the trigger RTL.
//   TRIG_DATA_WIDTH   default width of the probed bus, pattern and mask
//   TRIG_COUNT_WIDTH  default width of the consecutive-hit counter
//   trig_mode_t       LEVEL / RISING / FALLING / CHANGE compare modes
//   trig_state_t      IDLE / WAIT_PRIMED / ARMED / FIRED, as seen on o_state
// ----------------------------------------------------------------------------
package ila_trigger_gen_pkg;

   localparam int TRIG_DATA_WIDTH  = 8;
   localparam int TRIG_COUNT_WIDTH = 8;

   typedef enum logic [1:0] {
      TRIG_MODE_LEVEL   = 2'b00,
      TRIG_MODE_RISING  = 2'b01,
      TRIG_MODE_FALLING = 2'b10,
      TRIG_MODE_CHANGE  = 2'b11
   } trig_mode_t;

   typedef enum logic [1:0] {
      TRIG_ST_IDLE        = 2'd0,
      TRIG_ST_WAIT_PRIMED = 2'd1,
      TRIG_ST_ARMED       = 2'd2,
      TRIG_ST_FIRED       = 2'd3
   } trig_state_t;

endpackage

// File: rtl/ila_trigger_gen_match.sv
// ----------------------------------------------------------------------------
// ila_trigger_match
// Sample pipeline and masked compare for the trigger qualifier. Registers the
// probed bus (d_q) and keeps the previous sample (d_p), evaluates the selected
// compare mode and presents a registered hit one cycle later.
//   clk, reset    system clock, synchronous active-high reset
//   i_data        probed bus
//   i_pattern     latched compare value
//   i_mask        latched participation mask (1 = bit is compared)
//   i_mode        latched compare mode
//   i_sample_en   1 when the sample taken on this edge belongs to ARMED
//   o_hit         registered hit, qualified by i_sample_en
// ----------------------------------------------------------------------------
module ila_trigger_match
   import ila_trigger_gen_pkg::*;
#(
   parameter int DATA_WIDTH = TRIG_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [DATA_WIDTH-1:0] i_pattern,
   input  logic [DATA_WIDTH-1:0] i_mask,
   input  trig_mode_t            i_mode,
   input  logic                  i_sample_en,
   output logic                  o_hit
);

   logic [DATA_WIDTH-1:0] d_q;
   logic [DATA_WIDTH-1:0] d_p;
   logic                  q_valid;     // d_q was sampled while ARMED
   logic                  prev_valid;  // d_p was sampled while ARMED
   logic                  eq_q;
   logic                  eq_p;
   logic                  changed;
   logic                  hit;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      eq_q    = ((d_q ^ i_pattern) & i_mask) == '0;
      eq_p    = ((d_p ^ i_pattern) & i_mask) == '0;
      changed = ((d_q ^ d_p) & i_mask) != '0;
      hit     = 1'b0;
      case (i_mode)
         TRIG_MODE_LEVEL:   hit = q_valid & eq_q;
         TRIG_MODE_RISING:  hit = q_valid & prev_valid & !eq_p & eq_q;
         TRIG_MODE_FALLING: hit = q_valid & prev_valid & eq_p & !eq_q;
         TRIG_MODE_CHANGE:  hit = q_valid & prev_valid & changed;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so d_p picks up the
   // old d_q, not the value being written on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_q        <= '0;
         d_p        <= '0;
         q_valid    <= 1'b0;
         prev_valid <= 1'b0;
         o_hit      <= 1'b0;
      end else begin
         d_q        <= i_data;
         d_p        <= d_q;
         // Validity follows the samples down the pipe, so edge/change modes
         // only compare two samples that were both taken in ARMED.
         q_valid    <= i_sample_en;
         prev_valid <= q_valid & i_sample_en;
         o_hit      <= hit & i_sample_en;
      end
   end

endmodule

// File: rtl/ila_trigger_gen.sv
// ----------------------------------------------------------------------------
// ila_trigger_gen
// Trigger qualifier ahead of the ILA capture top. Latches a pattern/mask/mode
// on arm, waits for the capture buffer to report primed, then searches the
// probed bus and raises a held trigger on a qualified hit or a forced fire.
//   clk, reset      system clock, synchronous active-high reset
//   i_data          probed signals
//   i_pattern       compare value (latched on arm)
//   i_mask          compare mask, 1 = bit participates (latched on arm)
//   i_mode          00 LEVEL, 01 RISING, 10 FALLING, 11 CHANGE (latched on arm)
//   i_match_count   LEVEL consecutive hits required, 0 behaves as 1
//   i_arm           pulse: start a search from IDLE
//   i_disarm        pulse: abort from any state, wins over arm/force
//   i_force         pulse: fire now from WAIT_PRIMED or ARMED
//   i_primed        capture buffer primed flag
//   o_trigger       registered trigger, held high while FIRED
//   o_armed         registered, high while ARMED
//   o_state         current state encoding (trig_state_t)
// Latency: a qualifying sample on edge N raises o_trigger on edge N+2.
// ----------------------------------------------------------------------------
module ila_trigger_gen
   import ila_trigger_gen_pkg::*;
#(
   parameter int DATA_WIDTH  = TRIG_DATA_WIDTH,
   parameter int COUNT_WIDTH = TRIG_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_WIDTH-1:0]  i_data,
   input  logic [DATA_WIDTH-1:0]  i_pattern,
   input  logic [DATA_WIDTH-1:0]  i_mask,
   input  logic [1:0]             i_mode,
   input  logic [COUNT_WIDTH-1:0] i_match_count,
   input  logic                   i_arm,
   input  logic                   i_disarm,
   input  logic                   i_force,
   input  logic                   i_primed,
   output logic                   o_trigger,
   output logic                   o_armed,
   output logic [1:0]             o_state
);

   trig_state_t            state;
   trig_state_t            state_nxt;
   trig_mode_t             mode_q;
   logic [DATA_WIDTH-1:0]  pattern_q;
   logic [DATA_WIDTH-1:0]  mask_q;
   logic [COUNT_WIDTH-1:0] need_q;       // max(i_match_count, 1)
   logic [COUNT_WIDTH-1:0] hit_cnt;
   logic [COUNT_WIDTH-1:0] hit_cnt_nxt;
   logic [COUNT_WIDTH:0]   cnt_plus1;    // one bit wider so all-ones + 1 compares correctly
   logic                   level_done;
   logic                   hit;

   ila_trigger_match #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_match (
      .clk         (clk),
      .reset       (reset),
      .i_data      (i_data),
      .i_pattern   (pattern_q),
      .i_mask      (mask_q),
      .i_mode      (mode_q),
      .i_sample_en (state_nxt == TRIG_ST_ARMED),
      .o_hit       (hit)
   );

   assign cnt_plus1  = {1'b0, hit_cnt} + (COUNT_WIDTH + 1)'(1);
   assign level_done = cnt_plus1 >= {1'b0, need_q};
   assign o_state    = state;

   always_comb begin
      state_nxt   = state;
      hit_cnt_nxt = hit_cnt;
      if (i_disarm) begin
         state_nxt   = TRIG_ST_IDLE;
         hit_cnt_nxt = '0;
      end else begin
         case (state)
            TRIG_ST_IDLE: begin
               hit_cnt_nxt = '0;
               if (i_arm) state_nxt = TRIG_ST_WAIT_PRIMED;
            end
            TRIG_ST_WAIT_PRIMED: begin
               hit_cnt_nxt = '0;
               if (i_force)       state_nxt = TRIG_ST_FIRED;
               else if (i_primed) state_nxt = TRIG_ST_ARMED;
            end
            TRIG_ST_ARMED: begin
               if (i_force) begin
                  state_nxt   = TRIG_ST_FIRED;
                  hit_cnt_nxt = '0;
               end else if (!i_primed) begin
                  // Buffer lost its primed status: restart the search cleanly.
                  state_nxt   = TRIG_ST_WAIT_PRIMED;
                  hit_cnt_nxt = '0;
               end else if (!hit) begin
                  hit_cnt_nxt = '0;
               end else if (mode_q != TRIG_MODE_LEVEL || level_done) begin
                  state_nxt   = TRIG_ST_FIRED;
                  hit_cnt_nxt = '0;
               end else if (hit_cnt != '1) begin
                  hit_cnt_nxt = hit_cnt + COUNT_WIDTH'(1);
               end
            end
            TRIG_ST_FIRED: begin
               hit_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= TRIG_ST_IDLE;
         o_trigger <= 1'b0;
         o_armed   <= 1'b0;
         hit_cnt   <= '0;
         mode_q    <= TRIG_MODE_LEVEL;
         pattern_q <= '0;
         mask_q    <= '0;
         need_q    <= '0;
      end else begin
         state     <= state_nxt;
         o_trigger <= (state_nxt == TRIG_ST_FIRED);
         o_armed   <= (state_nxt == TRIG_ST_ARMED);
         hit_cnt   <= hit_cnt_nxt;
         // Configuration is only captured on an accepted arm.
         if (state == TRIG_ST_IDLE && i_arm && !i_disarm) begin
            mode_q    <= trig_mode_t'(i_mode);
            pattern_q <= i_pattern;
            mask_q    <= i_mask;
            need_q    <= (i_match_count == '0) ? COUNT_WIDTH'(1) : i_match_count;
         end
      end
   end

endmodule

// File: tb/tb_ila_trigger_gen.sv
// ----------------------------------------------------------------------------
// tb_ila_trigger_gen
// Directed bench for ila_trigger_gen. Each stimulus step pushes the outputs
// expected after the following rising edge; a monitor pops and compares one
// entry per edge, 1 time unit after the edge.
// ----------------------------------------------------------------------------
module tb_ila_trigger_gen;
   import ila_trigger_gen_pkg::*;

   localparam logic [1:0] S_I = TRIG_ST_IDLE;
   localparam logic [1:0] S_W = TRIG_ST_WAIT_PRIMED;
   localparam logic [1:0] S_A = TRIG_ST_ARMED;
   localparam logic [1:0] S_F = TRIG_ST_FIRED;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] i_data;
   logic [7:0] i_pattern;
   logic [7:0] i_mask;
   logic [1:0] i_mode;
   logic [7:0] i_match_count;
   logic       i_arm;
   logic       i_disarm;
   logic       i_force;
   logic       i_primed;
   logic       o_trigger;
   logic       o_armed;
   logic [1:0] o_state;

   typedef struct {
      logic       trig;
      logic       armed;
      logic [1:0] state;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ila_trigger_gen #(
      .DATA_WIDTH  (8),
      .COUNT_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_data        (i_data),
      .i_pattern     (i_pattern),
      .i_mask        (i_mask),
      .i_mode        (i_mode),
      .i_match_count (i_match_count),
      .i_arm         (i_arm),
      .i_disarm      (i_disarm),
      .i_force       (i_force),
      .i_primed      (i_primed),
      .o_trigger     (o_trigger),
      .o_armed       (o_armed),
      .o_state       (o_state)
   );

   // Monitor: one expected entry per rising edge, compared just after it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (o_trigger !== e.trig || o_armed !== e.armed || o_state !== e.state) begin
            failures++;
            $display("FAIL %s: got trig=%b armed=%b state=%0d, want trig=%b armed=%b state=%0d",
                     e.name, o_trigger, o_armed, o_state, e.trig, e.armed, e.state);
         end
      end
   end

   // One clock of stimulus; st is the state expected after the next edge.
   task automatic step(input string name, input logic [7:0] d, input logic arm,
                       input logic dis, input logic frc, input logic pr,
                       input logic rst, input logic [1:0] st);
      exp_t e;
      @(negedge clk);
      i_data   = d;
      i_arm    = arm;
      i_disarm = dis;
      i_force  = frc;
      i_primed = pr;
      reset    = rst;
      e.trig   = (st == S_F);
      e.armed  = (st == S_A);
      e.state  = st;
      e.name   = name;
      exp_q.push_back(e);
   endtask

   task automatic cfg(input logic [7:0] pat, input logic [7:0] msk,
                      input trig_mode_t mode, input logic [7:0] cnt);
      i_pattern     = pat;
      i_mask        = msk;
      i_mode        = mode;
      i_match_count = cnt;
   endtask

   initial begin
      logic [7:0] t1_data[6];
      t1_data = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5};

      reset = 1'b1; i_data = '0; i_arm = 0; i_disarm = 0; i_force = 0; i_primed = 0;
      cfg(8'h00, 8'h00, TRIG_MODE_LEVEL, 8'd0);
      step("reset0", 8'h00, 0, 0, 0, 0, 1, S_I);
      step("reset1", 8'h00, 0, 0, 0, 0, 1, S_I);
      step("idle",   8'h00, 0, 0, 0, 1, 0, S_I);

      // 1: LEVEL A5/FF, 3 consecutive hits; the 6th sample completes the run.
      cfg(8'hA5, 8'hFF, TRIG_MODE_LEVEL, 8'd3);
      step("t1_arm", 8'h00, 1, 0, 0, 1, 0, S_W);
      foreach (t1_data[i]) step($sformatf("t1_s%0d", i), t1_data[i], 0, 0, 0, 1, 0, S_A);
      step("t1_pipe",  8'h00, 0, 0, 0, 1, 0, S_A);
      step("t1_fire",  8'h00, 0, 0, 0, 1, 0, S_F);
      step("t1_hold",  8'h00, 0, 0, 0, 1, 0, S_F);
      step("t1_dis",   8'h00, 0, 1, 0, 1, 0, S_I);

      // 2: RISING on bit0, no fire on the first ARMED sample.
      cfg(8'h01, 8'h01, TRIG_MODE_RISING, 8'd5);
      step("t2_arm", 8'h01, 1, 0, 0, 1, 0, S_W);
      step("t2_s1",  8'h01, 0, 0, 0, 1, 0, S_A);
      step("t2_s2",  8'h00, 0, 0, 0, 1, 0, S_A);
      step("t2_s3",  8'h01, 0, 0, 0, 1, 0, S_A);
      step("t2_pipe",8'h01, 0, 0, 0, 1, 0, S_A);
      step("t2_fire",8'h01, 0, 0, 0, 1, 0, S_F);
      step("t2_dis", 8'h01, 0, 1, 0, 1, 0, S_I);
      // 2b: pre-arm 00 then 01 as the first ARMED sample must not count as an edge.
      step("t2b_arm", 8'h00, 1, 0, 0, 1, 0, S_W);
      for (int i = 0; i < 6; i++) step("t2b_nofire", 8'h01, 0, 0, 0, 1, 0, S_A);
      step("t2b_dis", 8'h01, 0, 1, 0, 1, 0, S_I);

      // 3: wait for primed with mask=00, then fire two edges after ARMED.
      cfg(8'h00, 8'h00, TRIG_MODE_LEVEL, 8'd0);
      step("t3_arm", 8'h3C, 1, 0, 0, 0, 0, S_W);
      for (int i = 0; i < 10; i++) step("t3_wait", 8'h3C, 0, 0, 0, 0, 0, S_W);
      step("t3_primed", 8'h3C, 0, 0, 0, 1, 0, S_A);
      step("t3_pipe",   8'h3C, 0, 0, 0, 1, 0, S_A);
      step("t3_fire",   8'h3C, 0, 0, 0, 1, 0, S_F);

      // 4: arm+disarm together in FIRED -> IDLE; a fresh arm is accepted.
      step("t4_armdis", 8'h3C, 1, 1, 0, 1, 0, S_I);
      step("t4_rearm",  8'h3C, 1, 0, 0, 1, 0, S_W);
      step("t4_armed",  8'h3C, 0, 0, 0, 1, 0, S_A);
      step("t4_pipe",   8'h3C, 0, 0, 0, 1, 0, S_A);
      step("t4_fire",   8'h3C, 0, 0, 0, 1, 0, S_F);
      step("t4_dis",    8'h3C, 0, 1, 0, 1, 0, S_I);

      // 5: CHANGE on high nibble, only low nibble toggles; then force.
      cfg(8'h00, 8'hF0, TRIG_MODE_CHANGE, 8'd0);
      step("t5_idle_force", 8'h00, 0, 0, 1, 1, 0, S_I);
      step("t5_arm", 8'h00, 1, 0, 0, 1, 0, S_W);
      for (int i = 1; i < 8; i++) step("t5_lownib", 8'(i), 0, 0, 0, 1, 0, S_A);
      step("t5_force", 8'h08, 0, 0, 1, 1, 0, S_F);
      step("t5_dis",   8'h08, 0, 1, 0, 1, 0, S_I);
      // 5b: disarm beats force.
      step("t5b_arm",    8'h00, 1, 0, 0, 1, 0, S_W);
      step("t5b_armed",  8'h00, 0, 0, 0, 1, 0, S_A);
      step("t5b_frcdis", 8'h00, 0, 1, 1, 1, 0, S_I);
      // 5c: force while waiting for primed.
      step("t5c_arm",   8'h00, 1, 0, 0, 0, 0, S_W);
      step("t5c_force", 8'h00, 0, 0, 1, 0, 0, S_F);
      step("t5c_dis",   8'h00, 0, 1, 0, 0, 0, S_I);
      // 5d: high-nibble change fires; arm while ARMED is ignored.
      step("t5d_arm",   8'h00, 1, 0, 0, 1, 0, S_W);
      step("t5d_s1",    8'h00, 0, 0, 0, 1, 0, S_A);
      step("t5d_s2",    8'h10, 1, 0, 0, 1, 0, S_A);
      step("t5d_pipe",  8'h10, 0, 0, 0, 1, 0, S_A);
      step("t5d_fire",  8'h10, 0, 0, 0, 1, 0, S_F);
      step("t5d_dis",   8'h10, 0, 1, 0, 1, 0, S_I);

      // FALLING on bit7.
      cfg(8'h80, 8'h80, TRIG_MODE_FALLING, 8'd0);
      step("tf_arm",  8'h80, 1, 0, 0, 1, 0, S_W);
      step("tf_s1",   8'h80, 0, 0, 0, 1, 0, S_A);
      step("tf_s2",   8'h00, 0, 0, 0, 1, 0, S_A);
      step("tf_pipe", 8'h00, 0, 0, 0, 1, 0, S_A);
      step("tf_fire", 8'h00, 0, 0, 0, 1, 0, S_F);
      step("tf_dis",  8'h00, 0, 1, 0, 1, 0, S_I);

      // 6: reset mid-count; afterwards three fresh hits are required.
      cfg(8'hA5, 8'hFF, TRIG_MODE_LEVEL, 8'd3);
      step("t6_arm",   8'hA5, 1, 0, 0, 1, 0, S_W);
      step("t6_s1",    8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t6_s2",    8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t6_s3",    8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t6_reset", 8'hA5, 0, 0, 0, 1, 1, S_I);
      step("t6_idle",  8'hA5, 0, 0, 0, 1, 0, S_I);
      step("t6_rearm", 8'hA5, 1, 0, 0, 1, 0, S_W);
      for (int i = 0; i < 4; i++) step("t6_count", 8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t6_fire",  8'hA5, 0, 0, 0, 1, 0, S_F);
      step("t6_dis",   8'hA5, 0, 1, 0, 1, 0, S_I);

      // 7: primed drops mid-count -> WAIT_PRIMED and counter restarts.
      step("t7_arm",    8'hA5, 1, 0, 0, 1, 0, S_W);
      step("t7_s1",     8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t7_s2",     8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t7_s3",     8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t7_unprime",8'hA5, 0, 0, 0, 0, 0, S_W);
      for (int i = 0; i < 4; i++) step("t7_count", 8'hA5, 0, 0, 0, 1, 0, S_A);
      step("t7_fire",   8'hA5, 0, 0, 0, 1, 0, S_F);
      step("t7_dis",    8'hA5, 0, 1, 0, 1, 0, S_I);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
